// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong match sequencer (idle, serve, play, scored, game over).
// Tracks both scores, paces serve/scored holds in video frames, drives ball control.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   newFrame       one-cycle pulse per video frame
//   start          level start request; only its rising edge is used
//   pause          level; freezes gameplay and frame counting
//   ballX          ball left column from the trajectory block
//   ballPause      hold ball motion (registered)
//   ballReset      one-clock pulse each time a serve begins
//   serveDir       0 = serve toward left, 1 = serve toward right
//   score0/score1  left/right player scores, saturating at WIN_SCORE
//   state          IDLE=0 SERVE=1 PLAY=2 SCORED=3 GAMEOVER=4
//   winner         0 = left, 1 = right (valid while gameOver)
//   gameOver       high while in GAMEOVER
module pong_game_ctrl #(
    parameter logic [12:0] WALL_LEFT     = 13'd0,
    parameter logic [12:0] WALL_RIGHT    = 13'd640,
    parameter int          BALL_W        = 10,
    parameter int          SERVE_FRAMES  = 60,
    parameter int          SCORED_FRAMES = 90,
    parameter int          WIN_SCORE     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newFrame,
    input  logic        start,
    input  logic        pause,
    input  logic [12:0] ballX,
    output logic        ballPause,
    output logic        ballReset,
    output logic        serveDir,
    output logic [3:0]  score0,
    output logic [3:0]  score1,
    output logic [2:0]  state,
    output logic        winner,
    output logic        gameOver
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        SCORED   = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam int MAXF = (SERVE_FRAMES > SCORED_FRAMES) ?
                          SERVE_FRAMES : SCORED_FRAMES;
    localparam int CLOG = $clog2(MAXF + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;

    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
    localparam logic [CW:0] SRV_LIM = (CW+1)'(SERVE_FRAMES);
    localparam logic [CW:0] SCR_LIM = (CW+1)'(SCORED_FRAMES);
    localparam logic [13:0] BW14    = 14'(BALL_W);

    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          start_q;
    logic          start_edge;
    logic          tick;
    logic [CW:0]   cnt_inc;
    logic [13:0]   right_edge;
    logic          miss_left;
    logic          miss_right;
    logic [3:0]    sc0_n, sc1_n;
    logic          dir_n, brst_n, bp_n, go_n, win_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s < WIN) ? s + 4'd1 : s;
    endfunction

    assign start_edge = start & ~start_q;
    assign tick       = newFrame & ~pause;
    assign cnt_inc    = {1'b0, cnt} + (CW+1)'(1);
    // Widened so a ball near the right wall cannot wrap past zero.
    assign right_edge = {1'b0, ballX} + BW14;
    assign miss_left  = (ballX <= WALL_LEFT);
    assign miss_right = (right_edge >= {1'b0, WALL_RIGHT});

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        sc0_n  = score0;
        sc1_n  = score1;
        dir_n  = serveDir;
        brst_n = 1'b0;

        unique case (st)
            IDLE, GAMEOVER: begin
                if (start_edge) begin
                    st_n   = SERVE;
                    sc0_n  = 4'd0;
                    sc1_n  = 4'd0;
                    dir_n  = 1'b0;
                    brst_n = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (cnt_inc >= SRV_LIM) st_n = PLAY;
                    else cnt_n = cnt_inc[CW-1:0];
                end
            end
            PLAY: begin
                // Left miss wins when both walls are touched in one frame.
                if (tick && miss_left) begin
                    sc1_n = sat_inc(score1);
                    dir_n = 1'b0;
                    st_n  = SCORED;
                end else if (tick && miss_right) begin
                    sc0_n = sat_inc(score0);
                    dir_n = 1'b1;
                    st_n  = SCORED;
                end
            end
            SCORED: begin
                if (tick) begin
                    if (cnt_inc >= SCR_LIM) begin
                        if (score0 == WIN || score1 == WIN) begin
                            st_n = GAMEOVER;
                        end else begin
                            st_n   = SERVE;
                            brst_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end
            default: st_n = IDLE;
        endcase

        // Every state starts its hold count from zero.
        if (st_n != st) cnt_n = '0;

        // Outputs follow the state being entered so they stay registered.
        bp_n  = (st_n == PLAY) ? pause : 1'b1;
        go_n  = (st_n == GAMEOVER);
        win_n = go_n && (sc1_n == WIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            score0    <= 4'd0;
            score1    <= 4'd0;
            serveDir  <= 1'b0;
            ballReset <= 1'b0;
            ballPause <= 1'b1;
            gameOver  <= 1'b0;
            winner    <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            start_q   <= start;
            score0    <= sc0_n;
            score1    <= sc1_n;
            serveDir  <= dir_n;
            ballReset <= brst_n;
            ballPause <= bp_n;
            gameOver  <= go_n;
            winner    <= win_n;
        end
    end

    assign state = st;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WALL_LEFT, default 13'd0, meaning left playfield column.
REQ-002 SHALL have parameter WALL_RIGHT, default 13'd640, meaning right playfield column (exclusive).
REQ-003 SHALL have parameter BALL_W, default 10, meaning ball width in pixels.
REQ-004 SHALL have parameter SERVE_FRAMES, default 60, meaning frames held before a serve.
REQ-005 SHALL have parameter SCORED_FRAMES, default 90, meaning frames held after a point.
REQ-006 SHALL have parameter WIN_SCORE, default 7, meaning points needed to win (1..15).
REQ-007 SHALL have ports: clk  in  1  single clock; one clock domain, and reset is synchronous and active-high.
REQ-008 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-009 SHALL have port: newFrame  in  1  one-cycle pulse per video frame.
REQ-010 SHALL have port: start  in  1  level, active-high start request (debounced upstream).
REQ-011 SHALL have port: pause  in  1  level, freezes gameplay.
REQ-012 SHALL have port: ballX  in  13  ball left column from ball_trajectory.
REQ-013 SHALL have ports: ballPause out 1; ballReset out 1 (one-cycle pulse); serveDir out 1 (0 = toward left, 1 = toward right).
REQ-014 SHALL have ports: score0 out 4 (left player); score1 out 4 (right player); state out 3; winner out 1 (0 = left, 1 = right); gameOver out 1.

Function
REQ-015 SHALL encode state as IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAMEOVER=4; all outputs registered.
REQ-016 SHALL detect start rising edge via a registered copy of start; only edges, not levels, trigger transitions.
REQ-017 IDLE: ballPause=1; on start edge -> SERVE, score0=score1=0, serveDir=0, ballReset pulsed in the same transition cycle.
REQ-018 SERVE: ballPause=1; frame counter cleared on entry, incremented per newFrame pulse; the newFrame pulse that brings the count to SERVE_FRAMES moves the FSM -> PLAY on the next clock.
REQ-019 PLAY: ballPause = pause; ball bounds tested only in cycles where newFrame=1 and pause=0.
REQ-020 PLAY miss-left: ballX <= WALL_LEFT -> score1 += 1, serveDir=0, -> SCORED.
REQ-021 PLAY miss-right: ballX + BALL_W >= WALL_RIGHT (14-bit sum, no wrap) -> score0 += 1, serveDir=1, -> SCORED.
REQ-022 Both miss conditions in one frame: left-miss takes priority; only score1 increments.
REQ-023 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-024 SCORED: ballPause=1; counts SCORED_FRAMES newFrame pulses; then if either score == WIN_SCORE -> GAMEOVER, else -> SERVE with ballReset pulsed.
REQ-025 GAMEOVER: ballPause=1, gameOver=1, winner = (score1 == WIN_SCORE); scores held; on start edge -> SERVE with behaviour identical to REQ-017.
REQ-026 pause=1 SHALL freeze the frame counter in SERVE and SCORED (newFrame pulses ignored); the state is held.
REQ-027 ballReset SHALL be high for exactly one clock per serve; it is never high in PLAY.
REQ-028 A start edge outside IDLE/GAMEOVER SHALL be ignored.
REQ-029 The frame counter SHALL be at least 8 bits and is cleared on every state entry.

Reset
REQ-030 On reset: state=IDLE, score0=score1=0, ballPause=1, ballReset=0, serveDir=0, winner=0, gameOver=0, counter=0, start-edge register=0.
REQ-031 Reset asserted mid-game SHALL return all outputs to REQ-030 values on the next clock, overriding every transition.

Verification (SERVE_FRAMES=2, SCORED_FRAMES=3, WIN_SCORE=2, WALL_RIGHT=640, BALL_W=10)
REQ-032 reset, then start 0->1 -> state=1, ballReset pulsed for 1 clock; after 2 newFrame pulses -> state=2, ballPause=0.
REQ-033 PLAY, ballX=0 on newFrame -> score1=1, serveDir=0, state=3; after 3 frames -> state=1 with one ballReset pulse.
REQ-034 PLAY, ballX=630 on newFrame -> score0 increments; ballX=629 -> no change.
REQ-035 score0 reaches 2 -> after SCORED the FSM enters GAMEOVER, gameOver=1, winner=0; start edge -> SERVE, scores=0.
REQ-036 pause=1 in SERVE across 5 newFrame pulses -> state stays 1; start toggled in PLAY -> no effect; reset in PLAY -> REQ-030 values.
